big_core_mem_arb: RTL

Two-requester arbiter and region sequencer for the big_core shared data-side memory space (D_MEM, CR_MEM, VGA_MEM). It sits between the core memory stage (port 0) and an external host/debug master (port 1) on one side, and the three region memories on the other. It grants one access per cycle with round-robin fairness and an optional bounded lock for read-modify-write. It decodes the target region, drives the region chip-selects, and routes fixed-latency read data back to the issuing requester.

---
 rtl/big_core_mem_arb.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/big_core_mem_arb.sv
// big_core_mem_arb: two-port round-robin arbiter with bounded lock, region decode and
// fixed-latency read-response routing for the big_core data-side memories.
module big_core_mem_arb #(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned LOCK_MAX   = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req0,
   input  logic        i_wr0,
   input  logic [31:0] i_addr0,
   input  logic [31:0] i_wr_data0,
   input  logic [3:0]  i_byte_en0,
   input  logic        i_lock0,
   output logic        o_ready0,
   output logic        o_rd_valid0,
   output logic [31:0] o_rd_data0,
   output logic        o_rd_err0,
   input  logic        i_req1,
   input  logic        i_wr1,
   input  logic [31:0] i_addr1,
   input  logic [31:0] i_wr_data1,
   input  logic [3:0]  i_byte_en1,
   input  logic        i_lock1,
   output logic        o_ready1,
   output logic        o_rd_valid1,
   output logic [31:0] o_rd_data1,
   output logic        o_rd_err1,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wr_data,
   output logic [3:0]  o_mem_byte_en,
   output logic        o_mem_wr,
   output logic        o_dmem_cs,
   output logic        o_cr_cs,
   output logic        o_vga_cs,
   input  logic [31:0] i_dmem_rd_data,
   input  logic [31:0] i_cr_rd_data,
   input  logic [31:0] i_vga_rd_data,
   output logic        o_lock_timeout
);

   localparam int unsigned CntW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

   typedef enum logic {StArb, StLocked} state_e;
   typedef enum logic [1:0] {RgNone, RgDMem, RgCr, RgVga} region_e;

   typedef struct packed {
      logic    valid;
      logic    port;
      region_e region;
      logic    err;
   } rsp_t;

   state_e          r_state, w_state_d;
   logic            r_owner, w_owner_d;
   logic            r_last_grant;
   logic [CntW-1:0] r_lock_cnt, w_lock_cnt_d, w_cnt_inc;
   logic            w_gnt0, w_gnt1, w_gnt_any;
   logic            w_wr, w_lock, w_owner_lock, w_lock_timeout;
   logic [31:0]     w_addr, w_wr_data, w_rsp_data;
   logic [3:0]      w_byte_en;
   region_e         w_region;
   rsp_t            w_load, w_rsp;
   rsp_t            r_pipe [RD_LATENCY];

   // Grants are held off while reset is asserted so every output reads 0.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (i_rst_n) begin
         if (r_state == StLocked) begin
            w_gnt0 = i_req0 && !r_owner;
            w_gnt1 = i_req1 && r_owner;
         end else if (i_req0 && i_req1) begin
            w_gnt0 = r_last_grant;
            w_gnt1 = !r_last_grant;
         end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
         end
      end
   end

   assign w_gnt_any = w_gnt0 || w_gnt1;
   assign w_addr    = w_gnt1 ? i_addr1    : i_addr0;
   assign w_wr_data = w_gnt1 ? i_wr_data1 : i_wr_data0;
   assign w_byte_en = w_gnt1 ? i_byte_en1 : i_byte_en0;
   assign w_wr      = w_gnt1 ? i_wr1      : i_wr0;
   assign w_lock    = w_gnt1 ? i_lock1    : i_lock0;

   always_comb begin
      w_region = RgNone;
      if (w_gnt_any) begin
         if (w_addr >= 32'h0000_2000 && w_addr <= 32'h0000_3FFF) begin
            w_region = RgDMem;
         end else if (w_addr >= 32'h0000_4000 && w_addr <= 32'h0000_4FFF) begin
            w_region = RgCr;
         end else if (w_addr >= 32'h0000_5000 && w_addr <= 32'h0001_15FF) begin
            w_region = RgVga;
         end
      end
   end

   assign o_ready0      = w_gnt0;
   assign o_ready1      = w_gnt1;
   assign o_mem_addr    = w_gnt_any ? w_addr    : '0;
   assign o_mem_wr_data = w_gnt_any ? w_wr_data : '0;
   assign o_mem_byte_en = w_gnt_any ? w_byte_en : '0;
   assign o_mem_wr      = w_gnt_any && w_wr && (w_region != RgNone);
   assign o_dmem_cs     = (w_region == RgDMem);
   assign o_cr_cs       = (w_region == RgCr);
   assign o_vga_cs      = (w_region == RgVga);

   assign w_cnt_inc    = r_lock_cnt + 1'b1;
   assign w_owner_lock = r_owner ? i_lock1 : i_lock0;

   always_comb begin
      w_state_d      = r_state;
      w_owner_d      = r_owner;
      w_lock_cnt_d   = r_lock_cnt;
      w_lock_timeout = 1'b0;
      unique case (r_state)
         StArb: begin
            if (w_gnt_any && w_lock) begin
               w_state_d    = StLocked;
               w_owner_d    = w_gnt1;
               w_lock_cnt_d = '0;
            end
         end
         StLocked: begin
            w_lock_cnt_d = (r_lock_cnt == CntLast) ? CntLast : w_cnt_inc;
            if (!w_owner_lock) begin
               w_state_d    = StArb;
               w_lock_cnt_d = '0;
            end else if (w_cnt_inc == CntLast) begin
               // Entry access plus LOCK_MAX-1 locked cycles have been spent.
               w_state_d      = StArb;
               w_lock_cnt_d   = '0;
               w_lock_timeout = 1'b1;
            end
         end
      endcase
   end

   assign o_lock_timeout = w_lock_timeout;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StArb;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_lock_cnt   <= '0;
      end else begin
         r_state    <= w_state_d;
         r_owner    <= w_owner_d;
         r_lock_cnt <= w_lock_cnt_d;
         if (w_gnt_any) begin
            r_last_grant <= w_gnt1;
         end
      end
   end

   always_comb begin
      w_load        = '0;
      w_load.valid  = w_gnt_any && !w_wr;
      w_load.port   = w_gnt1;
      w_load.region = w_region;
      w_load.err    = (w_region == RgNone);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= w_load;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign w_rsp = r_pipe[RD_LATENCY-1];

   always_comb begin
      w_rsp_data = '0;
      case (w_rsp.region)
         RgDMem:  w_rsp_data = i_dmem_rd_data;
         RgCr:    w_rsp_data = i_cr_rd_data;
         RgVga:   w_rsp_data = i_vga_rd_data;
         default: w_rsp_data = '0;
      endcase
   end

   assign o_rd_valid0 = w_rsp.valid && !w_rsp.port;
   assign o_rd_valid1 = w_rsp.valid && w_rsp.port;
   assign o_rd_err0   = o_rd_valid0 && w_rsp.err;
   assign o_rd_err1   = o_rd_valid1 && w_rsp.err;
   assign o_rd_data0  = o_rd_valid0 ? w_rsp_data : '0;
   assign o_rd_data1  = o_rd_valid1 ? w_rsp_data : '0;

endmodule
